// File: rtl/vdcram_ctl_pkg.sv
// Shared types for the VDC RAM controller: block-engine states and the
// requester/grant encoding used by the arbiter and the read-return pipeline.
package vdcram_ctl_pkg;

    typedef enum logic [2:0] {
        BLK_IDLE,
        BLK_FILL_WR,
        BLK_COPY_RD,
        BLK_COPY_WAIT,
        BLK_COPY_WR,
        BLK_DONE
    } blk_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CPU,
        GNT_BLK
    } gnt_t;

    // One bit wider than the command count so that a count of 0 can mean 256.
    localparam int BLK_CNT_W = 9;

endpackage

// File: rtl/vdcram_blk.sv
// Block fill/copy engine: one RAM access request at a time, holds its
// state and captured byte whenever the arbiter gives the slot elsewhere.
module vdcram_blk
    import vdcram_ctl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     copy_i,
    input  logic [ADDRESS_WIDTH-1:0] src_i,
    input  logic [ADDRESS_WIDTH-1:0] dst_i,
    input  logic [7:0]               count_i,
    input  logic [DATA_WIDTH-1:0]    fill_i,
    input  logic                     gnt_i,
    input  logic [DATA_WIDTH-1:0]    ram_dao_i,
    output logic                     req_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0]    wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRESS_WIDTH-1:0] src_o,
    output logic [ADDRESS_WIDTH-1:0] dst_o
);

    blk_state_t                 state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   src_q, src_d;
    logic [ADDRESS_WIDTH-1:0]   dst_q, dst_d;
    logic [BLK_CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      fill_q, fill_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLK_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        data_d  = data_q;
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = dst_q;
        wdata_o = data_q;
        case (state_q)
            BLK_IDLE: begin
                if (start_i) begin
                    src_d   = src_i;
                    dst_d   = dst_i;
                    cnt_d   = {count_i == 8'd0, count_i};
                    fill_d  = fill_i;
                    state_d = copy_i ? BLK_COPY_RD : BLK_FILL_WR;
                end
            end
            BLK_FILL_WR: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                wdata_o = fill_q;
                if (gnt_i) begin
                    dst_d = dst_q + ADDRESS_WIDTH'(1);
                    cnt_d = cnt_q - BLK_CNT_W'(1);
                    if (cnt_q == BLK_CNT_W'(1)) state_d = BLK_DONE;
                end
            end
            BLK_COPY_RD: begin
                req_o  = 1'b1;
                addr_o = src_q;
                if (gnt_i) state_d = BLK_COPY_WAIT;
            end
            // RAM data for the read granted last cycle is on ram_dao now.
            BLK_COPY_WAIT: begin
                data_d  = ram_dao_i;
                state_d = BLK_COPY_WR;
            end
            BLK_COPY_WR: begin
                req_o = 1'b1;
                we_o  = 1'b1;
                if (gnt_i) begin
                    src_d   = src_q + ADDRESS_WIDTH'(1);
                    dst_d   = dst_q + ADDRESS_WIDTH'(1);
                    cnt_d   = cnt_q - BLK_CNT_W'(1);
                    state_d = (cnt_q == BLK_CNT_W'(1)) ? BLK_DONE : BLK_COPY_RD;
                end
            end
            BLK_DONE: state_d = BLK_IDLE;
            default:  state_d = BLK_IDLE;
        endcase
    end

    assign busy_o = (state_q != BLK_IDLE);
    assign done_o = (state_q == BLK_DONE);
    assign src_o  = src_q;
    assign dst_o  = dst_q;

endmodule

// File: rtl/vdcram_ctl.sv
// VDC RAM controller: single-port arbiter (display > CPU > block engine)
// with per-requester pending registers and a two-cycle read-return path.
module vdcram_ctl
    import vdcram_ctl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_req,
    input  logic [ADDRESS_WIDTH-1:0] disp_addr,
    output logic                     disp_ack,
    output logic [DATA_WIDTH-1:0]    disp_data,
    input  logic                     cpu_rd,
    input  logic                     cpu_wr,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ack,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    input  logic                     blk_start,
    input  logic                     blk_copy,
    input  logic [ADDRESS_WIDTH-1:0] blk_src,
    input  logic [ADDRESS_WIDTH-1:0] blk_dst,
    input  logic [7:0]               blk_count,
    input  logic [DATA_WIDTH-1:0]    blk_fill,
    output logic                     blk_busy,
    output logic                     blk_done,
    output logic [ADDRESS_WIDTH-1:0] blk_src_next,
    output logic [ADDRESS_WIDTH-1:0] blk_dst_next,
    output logic                     ram_rd,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dai,
    input  logic [DATA_WIDTH-1:0]    ram_dao
);

    logic                     disp_pend_q, disp_pend_d;
    logic [ADDRESS_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic                     cpu_pend_q, cpu_pend_d;
    logic                     cpu_we_q, cpu_we_d;
    logic [ADDRESS_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_WIDTH-1:0]    cpu_wdata_q, cpu_wdata_d;
    gnt_t                     rd_id_q, rd_id_d;
    logic                     disp_ack_q, disp_ack_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic [DATA_WIDTH-1:0]    disp_data_q, disp_data_d;
    logic [DATA_WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;

    gnt_t                     gnt;
    logic                     blk_req, blk_we, blk_gnt;
    logic [ADDRESS_WIDTH-1:0] blk_addr;
    logic [DATA_WIDTH-1:0]    blk_wdata;
    logic                     disp_busy, cpu_busy;

    vdcram_blk #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_blk (
        .clk      (clk),
        .reset    (reset),
        .start_i  (blk_start),
        .copy_i   (blk_copy),
        .src_i    (blk_src),
        .dst_i    (blk_dst),
        .count_i  (blk_count),
        .fill_i   (blk_fill),
        .gnt_i    (blk_gnt),
        .ram_dao_i(ram_dao),
        .req_o    (blk_req),
        .we_o     (blk_we),
        .addr_o   (blk_addr),
        .wdata_o  (blk_wdata),
        .busy_o   (blk_busy),
        .done_o   (blk_done),
        .src_o    (blk_src_next),
        .dst_o    (blk_dst_next)
    );

    always_comb begin
        gnt      = GNT_NONE;
        ram_rd   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_dai  = '0;
        if (disp_pend_q)      gnt = GNT_DISP;
        else if (cpu_pend_q)  gnt = GNT_CPU;
        else if (blk_req)     gnt = GNT_BLK;
        case (gnt)
            GNT_DISP: begin
                ram_rd   = 1'b1;
                ram_addr = disp_addr_q;
            end
            GNT_CPU: begin
                ram_rd   = ~cpu_we_q;
                ram_we   = cpu_we_q;
                ram_addr = cpu_addr_q;
                ram_dai  = cpu_we_q ? cpu_wdata_q : '0;
            end
            GNT_BLK: begin
                ram_rd   = ~blk_we;
                ram_we   = blk_we;
                ram_addr = blk_addr;
                ram_dai  = blk_we ? blk_wdata : '0;
            end
            default: ;
        endcase
    end

    assign blk_gnt = (gnt == GNT_BLK);
    // A requester stays blocked from grant until its ack cycle.
    assign disp_busy = disp_pend_q | (rd_id_q == GNT_DISP);
    assign cpu_busy  = cpu_pend_q  | (rd_id_q == GNT_CPU);

    always_comb begin
        disp_pend_d = disp_pend_q;
        disp_addr_d = disp_addr_q;
        cpu_pend_d  = cpu_pend_q;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        disp_data_d = disp_data_q;
        cpu_rdata_d = cpu_rdata_q;
        rd_id_d     = GNT_NONE;
        disp_ack_d  = 1'b0;
        cpu_ack_d   = 1'b0;

        if (gnt == GNT_DISP) begin
            disp_pend_d = 1'b0;
            rd_id_d     = GNT_DISP;
        end
        if (gnt == GNT_CPU) begin
            cpu_pend_d = 1'b0;
            if (cpu_we_q) cpu_ack_d = 1'b1;
            else          rd_id_d   = GNT_CPU;
        end

        if (rd_id_q == GNT_DISP) begin
            disp_data_d = ram_dao;
            disp_ack_d  = 1'b1;
        end
        if (rd_id_q == GNT_CPU) begin
            cpu_rdata_d = ram_dao;
            cpu_ack_d   = 1'b1;
        end

        if (disp_req && !disp_busy) begin
            disp_pend_d = 1'b1;
            disp_addr_d = disp_addr;
        end
        if ((cpu_rd || cpu_wr) && !cpu_busy) begin
            cpu_pend_d  = 1'b1;
            cpu_we_d    = cpu_wr;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_pend_q <= 1'b0;
            disp_addr_q <= '0;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            rd_id_q     <= GNT_NONE;
            disp_ack_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            disp_data_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            disp_pend_q <= disp_pend_d;
            disp_addr_q <= disp_addr_d;
            cpu_pend_q  <= cpu_pend_d;
            cpu_we_q    <= cpu_we_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
            rd_id_q     <= rd_id_d;
            disp_ack_q  <= disp_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            disp_data_q <= disp_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign disp_ack  = disp_ack_q;
    assign disp_data = disp_data_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vdcram_ctl.sv
// Self-checking bench for vdcram_ctl: behavioural RAM, shadow-memory reference
// model, CPU vector table, contention/fill/copy/reset sequences, random traffic.
module tb_vdcram_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic        disp_ack;
    logic [7:0]  disp_data;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        blk_start = 1'b0, blk_copy = 1'b0;
    logic [15:0] blk_src = '0, blk_dst = '0;
    logic [7:0]  blk_count = '0, blk_fill = '0;
    logic        blk_busy, blk_done;
    logic [15:0] blk_src_next, blk_dst_next;
    logic        ram_rd, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dai;
    logic [7:0]  ram_dao = '0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        mem_init = 1'b0;
    int          excl_err = 0;
    int          n_pass = 0, n_total = 0;
    logic        any_out;
    bit          copy_run, rnd_done;

    always #5 clk = ~clk;

    vdcram_ctl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_data(disp_data),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .blk_start(blk_start), .blk_copy(blk_copy), .blk_src(blk_src), .blk_dst(blk_dst),
        .blk_count(blk_count), .blk_fill(blk_fill),
        .blk_busy(blk_busy), .blk_done(blk_done),
        .blk_src_next(blk_src_next), .blk_dst_next(blk_dst_next),
        .ram_rd(ram_rd), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dai(ram_dai), .ram_dao(ram_dao)
    );

    function automatic logic [7:0] pat(input int i);
        logic [15:0] a;
        a = 16'(i);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after ram_rd.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_dai;
            if (ram_rd) ram_dao <= mem[ram_addr];
        end
    end

    always @(negedge clk) if (ram_rd && ram_we) excl_err <= excl_err + 1;

    assign any_out = |{disp_ack, disp_data, cpu_ack, cpu_rdata, blk_busy, blk_done,
                       blk_src_next, blk_dst_next, ram_rd, ram_we, ram_addr, ram_dai};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic int mem_diff(input logic [15:0] start, input int n);
        int bad = 0;
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            if (mem[a] !== ref_mem[a]) bad++;
            a = a + 16'd1;
        end
        return bad;
    endfunction

    task automatic disp_op(input logic [15:0] a, input string nm);
        logic [7:0] exp;
        exp = ref_mem[a];
        disp_req = 1'b1; disp_addr = a;
        tick;
        disp_req = 1'b0;
        tick;
        check({nm, " early ack"}, 32'(disp_ack), 32'd0);
        tick;
        check({nm, " ack G+2"}, 32'(disp_ack), 32'd1);
        check({nm, " data"}, 32'(disp_data), 32'(exp));
    endtask

    // lat_exp = 0 accepts any bounded latency (used under contention).
    task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input int lat_exp, input string nm);
        int lat;
        cpu_wr = wr; cpu_rd = !wr; cpu_addr = a; cpu_wdata = d;
        if (wr) ref_mem[a] = d;
        tick;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        lat = 0;
        for (int i = 2; i <= 10 && lat == 0; i++) begin
            tick;
            if (cpu_ack) lat = i;
        end
        if (lat_exp > 0) check({nm, " ack latency"}, 32'(lat), 32'(lat_exp));
        else             check({nm, " ack seen"}, 32'(lat != 0), 32'd1);
        if (!wr) check({nm, " rdata"}, 32'(cpu_rdata), 32'(exp));
    endtask

    task automatic wait_blk(input int max, output int dones, output bit ok);
        dones = 0; ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (blk_done) dones++;
            if (!blk_busy) ok = 1'b1;
            else tick;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int dones, busy_seen;
        bit ok;
        logic [7:0] ec, ed;

        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 2};
        vecs[1] = '{1'b0, 16'h1234, 8'hA5, 3};
        vecs[2] = '{1'b1, 16'h0000, 8'h3C, 2};
        vecs[3] = '{1'b1, 16'hFFFF, 8'hC3, 2};
        vecs[4] = '{1'b0, 16'h0000, 8'h3C, 3};
        vecs[5] = '{1'b0, 16'hFFFF, 8'hC3, 3};
        vecs[6] = '{1'b1, 16'h1234, 8'h5A, 2};
        vecs[7] = '{1'b0, 16'h1234, 8'h5A, 3};
        vecs[8] = '{1'b0, 16'h0077, pat(16'h0077), 3};
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);

        // Reset state
        mem_init = 1'b1;
        tick;
        mem_init = 1'b0;
        tick;
        check("outputs during reset", 32'(any_out), 32'd0);
        reset = 1'b0;
        tick; tick;
        check("outputs idle after reset", 32'(any_out), 32'd0);

        // CPU vector table (write then read-back, same-address ordering)
        for (int i = 0; i < 9; i++)
            cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].data, vecs[i].lat, $sformatf("vec%0d", i));

        // Display and CPU read in the same cycle
        ec = ref_mem[16'h1234]; ed = ref_mem[16'h9000];
        disp_req = 1'b1; disp_addr = 16'h9000;
        cpu_rd = 1'b1; cpu_addr = 16'h1234;
        tick;
        disp_req = 1'b0; cpu_rd = 1'b0;
        check("contend G display", 32'({ram_rd, ram_we, ram_addr}), 32'({2'b10, 16'h9000}));
        tick;
        check("contend G+1 cpu", 32'({ram_rd, ram_we, ram_addr}), 32'({2'b10, 16'h1234}));
        tick;
        check("contend disp_ack first", 32'({disp_ack, cpu_ack}), 32'd2);
        check("contend disp_data", 32'(disp_data), 32'(ed));
        tick;
        check("contend cpu_ack second", 32'({disp_ack, cpu_ack}), 32'd1);
        check("contend cpu_rdata", 32'(cpu_rdata), 32'(ec));
        tick;

        // Fill across the address wrap, with a start while busy
        blk_copy = 1'b0; blk_src = 16'h0000; blk_dst = 16'hFFFE;
        blk_count = 8'd4; blk_fill = 8'h55; blk_start = 1'b1;
        tick;
        blk_start = 1'b0;
        check("fill busy after start", 32'(blk_busy), 32'd1);
        blk_copy = 1'b1; blk_src = 16'h0100; blk_dst = 16'h3000; blk_count = 8'd1;
        blk_start = 1'b1;
        tick;
        blk_start = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[16'(16'hFFFE + i)] = 8'h55;
        wait_blk(100, dones, ok);
        check("fill finished", 32'(ok), 32'd1);
        check("fill blk_done count", 32'(dones), 32'd1);
        check("fill blk_dst_next", 32'(blk_dst_next), 32'h0002);
        check("fill 0x0001 value", 32'(mem[16'h0001]), 32'h55);
        check("fill range bytes", 32'(mem_diff(16'hFFFD, 6)), 32'd0);
        check("busy start ignored", 32'(mem_diff(16'h3000, 1)), 32'd0);

        // 256-byte copy with a display read every third cycle
        copy_run = 1'b1;
        fork
            begin
                blk_copy = 1'b1; blk_src = 16'h0100; blk_dst = 16'h0200;
                blk_count = 8'd0; blk_start = 1'b1;
                tick;
                blk_start = 1'b0;
                wait_blk(3000, dones, ok);
                copy_run = 1'b0;
            end
            begin
                while (copy_run) disp_op(16'h8000 + 16'($urandom_range(0, 255)), "copy disp");
            end
        join
        for (int i = 0; i < 256; i++) ref_mem[16'h0200 + i] = ref_mem[16'h0100 + i];
        check("copy finished", 32'(ok), 32'd1);
        check("copy blk_done count", 32'(dones), 32'd1);
        check("copy blk_src_next", 32'(blk_src_next), 32'h0200);
        check("copy blk_dst_next", 32'(blk_dst_next), 32'h0300);
        check("copy 0x0210 value", 32'(mem[16'h0210]), 32'(pat(16'h0110)));
        check("copy range bytes", 32'(mem_diff(16'h01FF, 16'h0102)), 32'd0);

        // Random CPU traffic against concurrent display reads
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [15:0] a;
                    logic [7:0]  d;
                    bit wr;
                    wr = 1'($urandom_range(0, 1));
                    a  = 16'h0040 + 16'($urandom_range(0, 15));
                    d  = 8'($urandom);
                    cpu_op(wr, a, d, ref_mem[a], 0, "rnd cpu");
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    repeat ($urandom_range(0, 3)) tick;
                    disp_op(16'h8000 + 16'($urandom_range(0, 4095)), "rnd disp");
                end
            end
        join

        // Reset in the middle of a copy
        blk_copy = 1'b1; blk_src = 16'h4000; blk_dst = 16'h5000;
        blk_count = 8'd16; blk_start = 1'b1;
        tick;
        blk_start = 1'b0;
        repeat (8) tick;
        check("mid-copy busy", 32'(blk_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("outputs in mid-copy reset", 32'(any_out), 32'd0);
        tick;
        reset = 1'b0;
        dones = 0; busy_seen = 0;
        repeat (20) begin
            tick;
            if (blk_done) dones++;
            if (blk_busy) busy_seen++;
        end
        check("no blk_done after reset", 32'(dones), 32'd0);
        check("no busy after reset", 32'(busy_seen), 32'd0);
        check("outputs idle after abort", 32'(any_out), 32'd0);
        disp_op(16'h8123, "post-reset disp");

        check("ram_rd/ram_we exclusive", 32'(excl_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
